// File: rtl/fractal_pkg.sv
// Shared types and constants for the fractal scheduler and its slot tracking.
package fractal_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int FRAC_BITS      = 28;
    localparam int PIPELINE_DEPTH = 9;
    localparam int MAX_ITER       = 255;
    localparam int TAG_WIDTH      = 20;
    localparam int ITER_WIDTH     = 8;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
    } slot_meta_t;

    typedef struct packed {
        logic [ITER_WIDTH-1:0] iter;
        logic [TAG_WIDTH-1:0]  tag;
    } result_t;

    // What the scheduler does with the kernel slot presented this cycle.
    typedef enum logic [1:0] {
        SLOT_RECIRC,
        SLOT_INJECT,
        SLOT_BUBBLE
    } slot_action_t;

endpackage

// File: rtl/fractal_slot_pipe.sv
// Resettable delay line of slot metadata, aligned with the kernel latency.
module fractal_slot_pipe
    import fractal_pkg::*;
#(
    parameter int DEPTH = PIPELINE_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  slot_meta_t din,
    output slot_meta_t dout
);

    slot_meta_t stages [DEPTH];

    // Shift metadata one stage per cycle; reset clears every valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/fractal_scheduler.sv
// Issue/recirculation controller for fractal_kernel: injects new pixels into
// free slots, recirculates unfinished ones and retires finished results.
module fractal_scheduler #(
    parameter int PIPELINE_DEPTH = fractal_pkg::PIPELINE_DEPTH,
    parameter int DATA_WIDTH     = fractal_pkg::DATA_WIDTH,
    parameter int TAG_WIDTH      = fractal_pkg::TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_cr,
    input  logic [DATA_WIDTH-1:0] s_ci,
    input  logic [TAG_WIDTH-1:0]  s_tag,
    output logic [DATA_WIDTH-1:0] k_zr,
    output logic [DATA_WIDTH-1:0] k_zi,
    output logic [DATA_WIDTH-1:0] k_cr,
    output logic [DATA_WIDTH-1:0] k_ci,
    output logic [7:0]            k_iter,
    output logic                  k_finished,
    output logic                  k_inc_enabled,
    input  logic [DATA_WIDTH-1:0] k_zr_ret,
    input  logic [DATA_WIDTH-1:0] k_zi_ret,
    input  logic [DATA_WIDTH-1:0] k_cr_ret,
    input  logic [DATA_WIDTH-1:0] k_ci_ret,
    input  logic [7:0]            k_iter_ret,
    input  logic                  k_finished_ret,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [7:0]            m_iter,
    output logic [TAG_WIDTH-1:0]  m_tag
);

    import fractal_pkg::*;

    slot_meta_t   slot;
    slot_meta_t   push;
    slot_action_t action;
    result_t      out_q;
    logic         m_valid_q;
    logic         retire;
    logic         slot_free;

    // The slot whose data is on k_*_ret right now.
    fractal_slot_pipe #(
        .DEPTH(PIPELINE_DEPTH)
    ) u_slot_pipe (
        .clk  (clk),
        .reset(reset),
        .din  (push),
        .dout (slot)
    );

    // A finished slot leaves only when the output register can take it;
    // otherwise it keeps circulating with its iteration count frozen.
    assign retire    = slot.valid && k_finished_ret && (!m_valid_q || m_ready);
    assign slot_free = !slot.valid || retire;
    assign s_ready   = slot_free && !reset;

    // Choose what enters the kernel this cycle.
    always_comb begin
        action = SLOT_BUBBLE;
        if (reset) begin
            action = SLOT_BUBBLE;
        end else if (!slot_free) begin
            action = SLOT_RECIRC;
        end else if (s_valid) begin
            action = SLOT_INJECT;
        end
    end

    // Drive kernel inputs and the metadata pushed alongside them.
    always_comb begin
        k_zr          = '0;
        k_zi          = '0;
        k_cr          = '0;
        k_ci          = '0;
        k_iter        = '0;
        k_finished    = 1'b1;
        k_inc_enabled = 1'b0;
        push          = '0;
        case (action)
            SLOT_RECIRC: begin
                k_zr          = k_zr_ret;
                k_zi          = k_zi_ret;
                k_cr          = k_cr_ret;
                k_ci          = k_ci_ret;
                k_iter        = k_iter_ret;
                k_finished    = k_finished_ret;
                k_inc_enabled = !k_finished_ret;
                push          = slot;
            end
            SLOT_INJECT: begin
                k_cr          = s_cr;
                k_ci          = s_ci;
                k_finished    = 1'b0;
                k_inc_enabled = 1'b1;
                push          = '{valid: 1'b1, tag: s_tag};
            end
            default: begin
            end
        endcase
    end

    // Output register: load on retirement, hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            out_q     <= '0;
        end else if (retire) begin
            m_valid_q <= 1'b1;
            out_q     <= '{iter: k_iter_ret, tag: slot.tag};
        end else if (m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign m_valid = m_valid_q;
    assign m_iter  = out_q.iter;
    assign m_tag   = out_q.tag;

endmodule

// File: tb/tb_fractal_scheduler.sv
// Self-checking bench for fractal_scheduler with a behavioural kernel model.
module tb_fractal_scheduler;

    localparam int D  = 9;
    localparam int DW = 32;
    localparam int TW = 20;
    localparam logic [31:0] C_ESC = 32'h2800_0000; // 2.5 in Q4.28

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_cr, s_ci;
    logic [TW-1:0] s_tag;
    logic [DW-1:0] k_zr, k_zi, k_cr, k_ci;
    logic [7:0]    k_iter;
    logic          k_finished, k_inc_enabled;
    logic [DW-1:0] k_zr_ret, k_zi_ret, k_cr_ret, k_ci_ret;
    logic [7:0]    k_iter_ret;
    logic          k_finished_ret;
    logic          m_valid, m_ready;
    logic [7:0]    m_iter;
    logic [TW-1:0] m_tag;

    always #5 clk = ~clk;

    fractal_scheduler #(
        .PIPELINE_DEPTH(D),
        .DATA_WIDTH    (DW),
        .TAG_WIDTH     (TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_cr          (s_cr),
        .s_ci          (s_ci),
        .s_tag         (s_tag),
        .k_zr          (k_zr),
        .k_zi          (k_zi),
        .k_cr          (k_cr),
        .k_ci          (k_ci),
        .k_iter        (k_iter),
        .k_finished    (k_finished),
        .k_inc_enabled (k_inc_enabled),
        .k_zr_ret      (k_zr_ret),
        .k_zi_ret      (k_zi_ret),
        .k_cr_ret      (k_cr_ret),
        .k_ci_ret      (k_ci_ret),
        .k_iter_ret    (k_iter_ret),
        .k_finished_ret(k_finished_ret),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_iter        (m_iter),
        .m_tag         (m_tag)
    );

    // ---------------- Mandelbrot arithmetic (Q4.28) ----------------
    function automatic logic signed [31:0] fx_mul(input logic signed [31:0] a, input logic signed [31:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return 32'(p >>> 28);
    endfunction

    function automatic bit escaped(input logic signed [31:0] zr, input logic signed [31:0] zi);
        longint a, b, lim;
        a = longint'(zr);
        b = longint'(zi);
        lim = 64'sd1 <<< 58; // 4.0 with 56 fractional bits
        return (a * a + b * b) > lim;
    endfunction

    // Iteration count the scheduler must report for pixel c: one pass per
    // z-step, stopping on the first pass whose incoming z has |z|^2 > 4.
    function automatic int ref_iter(input logic signed [31:0] cr, input logic signed [31:0] ci);
        logic signed [31:0] zr, zi, nr, ni;
        zr = '0;
        zi = '0;
        for (int k = 0; k < 255; k++) begin
            if (escaped(zr, zi)) return k + 1;
            nr = fx_mul(zr, zr) - fx_mul(zi, zi) + cr;
            ni = 32'(2 * fx_mul(zr, zi)) + ci;
            zr = nr;
            zi = ni;
        end
        return 255;
    endfunction

    // ---------------- Kernel model: D-deep pipeline ----------------
    typedef struct packed {
        logic signed [31:0] zr, zi, cr, ci;
        logic [7:0]         iter;
        logic               fin;
    } kst_t;

    kst_t kpipe [D];

    function automatic kst_t kstep(input kst_t i, input logic inc);
        kst_t o;
        logic [7:0] ni;
        o = i;
        if (!i.fin) begin
            ni     = i.iter + 8'(inc);
            o.iter = ni;
            o.fin  = escaped(i.zr, i.zi) || (ni == 8'd255);
            o.zr   = fx_mul(i.zr, i.zr) - fx_mul(i.zi, i.zi) + i.cr;
            o.zi   = 32'(2 * fx_mul(i.zr, i.zi)) + i.ci;
        end
        return o;
    endfunction

    always @(posedge clk) begin
        kpipe[0] <= kstep('{zr: k_zr, zi: k_zi, cr: k_cr, ci: k_ci, iter: k_iter, fin: k_finished}, k_inc_enabled);
        for (int i = 1; i < D; i++) kpipe[i] <= kpipe[i-1];
    end

    assign k_zr_ret       = kpipe[D-1].zr;
    assign k_zi_ret       = kpipe[D-1].zi;
    assign k_cr_ret       = kpipe[D-1].cr;
    assign k_ci_ret       = kpipe[D-1].ci;
    assign k_iter_ret     = kpipe[D-1].iter;
    assign k_finished_ret = kpipe[D-1].fin;

    // ---------------- Monitor / scoreboard ----------------
    int cyc = 0;
    int res_tag[$];
    int res_iter[$];
    int res_cyc[$];
    int exp_iter[int];
    int mvalid_seen = 0;
    int checks = 0;
    int passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && s_valid && s_ready) exp_iter[int'(s_tag)] = ref_iter(s_cr, s_ci);
        if (m_valid) mvalid_seen++;
        if (m_valid && m_ready) begin
            res_tag.push_back(int'(m_tag));
            res_iter.push_back(int'(m_iter));
            res_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        res_tag.delete();
        res_iter.delete();
        res_cyc.delete();
        exp_iter.delete();
        mvalid_seen = 0;
    endtask

    task automatic send(input logic [31:0] cr, input logic [31:0] ci, input int tag, output int t);
        bit ok;
        s_valid = 1'b1;
        s_cr    = cr;
        s_ci    = ci;
        s_tag   = TW'(tag);
        ok      = 1'b0;
        t       = -1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                t  = cyc;
            end
            step();
        end
        s_valid = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout: tag %0d never accepted (s_ready stayed 0), required acceptance", tag);
        end
    endtask

    task automatic wait_results(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && res_tag.size() < n; i++) step();
        ok = (res_tag.size() >= n);
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        reset   = 1'b1;
        s_valid = 1'b1;
        s_cr    = 32'h1234_5678;
        s_ci    = 32'h0000_0042;
        s_tag   = '0;
        m_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b expected 0", s_ready); else passes++;
        checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b expected 0", m_valid); else passes++;
        checks++; if (m_iter !== 8'd0 || m_tag !== '0) $display("FAIL rst_m_data: got iter %0d tag %0d expected 0/0", m_iter, m_tag); else passes++;
        checks++;
        if (k_finished !== 1'b1 || k_inc_enabled !== 1'b0 || k_cr !== '0 || k_ci !== '0)
            $display("FAIL rst_bubble: got fin %b inc %b cr %h ci %h expected 1/0/0/0", k_finished, k_inc_enabled, k_cr, k_ci);
        else passes++;
        step();
        reset   = 1'b0;
        s_valid = 1'b0;
        clear_log();
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) $display("FAIL rst_release_s_ready: got %b expected 1", s_ready); else passes++;
        step();
    endtask

    task automatic test_escape_pass2();
        int t;
        bit ok;
        clear_log();
        send(C_ESC, 32'h0, 5, t);
        wait_results(1, 3 * D + 10, ok);
        checks++;
        if (!ok) $display("FAIL esc_timeout: got %0d results expected 1", res_tag.size());
        else begin
            passes++;
            checks++; if (res_iter[0] != 2) $display("FAIL esc_iter: got %0d expected 2", res_iter[0]); else passes++;
            checks++; if (res_tag[0] != 5) $display("FAIL esc_tag: got %0d expected 5", res_tag[0]); else passes++;
            checks++; if (res_cyc[0] != t + 2 * D + 1) $display("FAIL esc_latency: got cycle %0d expected %0d", res_cyc[0], t + 2 * D + 1); else passes++;
        end
        repeat (3 * D) step();
        checks++; if (mvalid_seen != 1) $display("FAIL esc_single_beat: got %0d valid cycles expected 1", mvalid_seen); else passes++;
    endtask

    task automatic test_max_iter();
        int t;
        bit ok;
        clear_log();
        send(32'h0, 32'h0, 7, t);
        wait_results(1, 255 * D + 20, ok);
        checks++;
        if (!ok) $display("FAIL max_timeout: got %0d results expected 1", res_tag.size());
        else begin
            passes++;
            checks++; if (res_iter[0] != 255 || res_tag[0] != 7) $display("FAIL max_result: got iter %0d tag %0d expected 255/7", res_iter[0], res_tag[0]); else passes++;
            checks++; if (res_cyc[0] != t + 255 * D + 1) $display("FAIL max_latency: got cycle %0d expected %0d", res_cyc[0], t + 255 * D + 1); else passes++;
        end
        repeat (20) step();
        checks++; if (res_tag.size() != 1) $display("FAIL max_count: got %0d results expected 1", res_tag.size()); else passes++;
    endtask

    task automatic test_fill_out_of_order();
        int t, t0, t8;
        bit ok;
        bit seen[int];
        clear_log();
        t0 = 0;
        t8 = 0;
        for (int i = 0; i < 9; i++) begin
            send((i % 2) ? C_ESC : 32'h0, 32'h0, i, t);
            if (i == 0) t0 = t;
            if (i == 8) t8 = t;
        end
        checks++; if (t8 != t0 + 8) $display("FAIL fill_back_to_back: got last accept %0d expected %0d", t8, t0 + 8); else passes++;
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) $display("FAIL fill_s_ready: got %b expected 0 with all slots busy", s_ready); else passes++;
        wait_results(9, 256 * D + 30, ok);
        checks++;
        if (!ok) $display("FAIL fill_timeout: got %0d results expected 9", res_tag.size());
        else begin
            passes++;
            checks++; if (res_tag[0] != 1) $display("FAIL fill_first_retired: got tag %0d expected 1", res_tag[0]); else passes++;
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (res_tag[i] < 0 || res_tag[i] > 8 || seen.exists(res_tag[i]))
                    $display("FAIL fill_tag_unique: got tag %0d expected unseen tag in 0..8", res_tag[i]);
                else passes++;
                seen[res_tag[i]] = 1'b1;
                checks++;
                if (res_iter[i] != ((res_tag[i] % 2) ? 2 : 255))
                    $display("FAIL fill_iter: tag %0d got %0d expected %0d", res_tag[i], res_iter[i], (res_tag[i] % 2) ? 2 : 255);
                else passes++;
            end
        end
        repeat (20) step();
        checks++; if (res_tag.size() != 9) $display("FAIL fill_count: got %0d results expected 9", res_tag.size()); else passes++;
    endtask

    task automatic test_output_stall();
        int t;
        bit ok, got, stable;
        logic [7:0]    v_iter;
        logic [TW-1:0] v_tag;
        clear_log();
        m_ready = 1'b0;
        send(C_ESC, 32'h0, 10, t);
        send(C_ESC, 32'h0, 11, t);
        send(C_ESC, 32'h0, 12, t);
        got = 1'b0;
        for (int i = 0; i < 4 * D && !got; i++) begin
            @(negedge clk);
            got = m_valid;
            if (!got) step();
        end
        checks++;
        if (!got) $display("FAIL stall_timeout: m_valid stayed 0 expected 1");
        else begin
            passes++;
            v_iter = m_iter;
            v_tag  = m_tag;
            checks++; if (v_iter !== 8'd2 || v_tag !== TW'(10)) $display("FAIL stall_first: got iter %0d tag %0d expected 2/10", v_iter, v_tag); else passes++;
            stable = 1'b1;
            for (int i = 0; i < 100; i++) begin
                step();
                @(negedge clk);
                if (m_valid !== 1'b1 || m_iter !== v_iter || m_tag !== v_tag) stable = 1'b0;
            end
            checks++; if (!stable) $display("FAIL stall_hold: got iter %0d tag %0d valid %b expected held 2/10/1", m_iter, m_tag, m_valid); else passes++;
        end
        step();
        m_ready = 1'b1;
        wait_results(3, 4 * D + 10, ok);
        checks++;
        if (!ok) $display("FAIL stall_release_timeout: got %0d results expected 3", res_tag.size());
        else begin
            passes++;
            checks++; if (res_tag[0] != 10) $display("FAIL stall_release_order: got tag %0d expected 10", res_tag[0]); else passes++;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (res_iter[i] != 2 || res_tag[i] != 10 + i)
                    $display("FAIL stall_release_result: got iter %0d tag %0d expected 2/%0d", res_iter[i], res_tag[i], 10 + i);
                else passes++;
            end
        end
        repeat (10) step();
        checks++; if (res_tag.size() != 3) $display("FAIL stall_count: got %0d results expected 3", res_tag.size()); else passes++;
    endtask

    task automatic test_same_cycle();
        int t20, t30, t;
        bit ok;
        clear_log();
        send(C_ESC, 32'h0, 20, t20);
        for (int i = 21; i <= 28; i++) send(32'h0, 32'h0, i, t);
        send(C_ESC, 32'h0, 30, t30);
        checks++; if (t30 != t20 + 2 * D) $display("FAIL same_accept: got accept cycle %0d expected %0d", t30, t20 + 2 * D); else passes++;
        wait_results(2, 3 * D + 10, ok);
        checks++;
        if (!ok) $display("FAIL same_timeout: got %0d results expected 2", res_tag.size());
        else begin
            passes++;
            checks++;
            if (res_tag[0] != 20 || res_iter[0] != 2 || res_cyc[0] != t20 + 2 * D + 1)
                $display("FAIL same_retire: got tag %0d iter %0d cycle %0d expected 20/2/%0d", res_tag[0], res_iter[0], res_cyc[0], t20 + 2 * D + 1);
            else passes++;
            checks++;
            if (res_tag[1] != 30 || res_iter[1] != 2 || res_cyc[1] != t30 + 2 * D + 1)
                $display("FAIL same_new_pixel: got tag %0d iter %0d cycle %0d expected 30/2/%0d", res_tag[1], res_iter[1], res_cyc[1], t30 + 2 * D + 1);
            else passes++;
        end
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        clear_log();
    endtask

    task automatic test_reset_mid();
        int t;
        bit ok, got;
        clear_log();
        m_ready = 1'b0;
        send(C_ESC, 32'h0, 40, t);
        got = 1'b0;
        for (int i = 0; i < 4 * D && !got; i++) begin
            @(negedge clk);
            got = m_valid;
            step();
        end
        for (int i = 41; i <= 45; i++) send(C_ESC, 32'h0, i, t);
        reset = 1'b1;
        repeat (2) step();
        @(negedge clk);
        checks++; if (m_valid !== 1'b0 || s_ready !== 1'b0) $display("FAIL rmid_in_reset: got m_valid %b s_ready %b expected 0/0", m_valid, s_ready); else passes++;
        step();
        reset   = 1'b0;
        m_ready = 1'b1;
        clear_log();
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) $display("FAIL rmid_s_ready: got %b expected 1", s_ready); else passes++;
        repeat (6 * D) step();
        checks++; if (mvalid_seen != 0) $display("FAIL rmid_stale: got %0d valid cycles expected 0", mvalid_seen); else passes++;
        send(C_ESC, 32'h0, 46, t);
        wait_results(1, 3 * D + 10, ok);
        checks++;
        if (!ok || res_tag[0] != 46 || res_iter[0] != 2)
            $display("FAIL rmid_after: got %0d results (first tag %0d) expected tag 46 iter 2", res_tag.size(), ok ? res_tag[0] : -1);
        else passes++;
    endtask

    task automatic test_random();
        localparam int N = 24;
        int sent;
        bit acc;
        clear_log();
        sent = 0;
        for (int c = 0; c < 30000 && !(sent == N && res_tag.size() >= N); c++) begin
            if (!s_valid && sent < N && $urandom_range(0, 1) == 1) begin
                s_valid = 1'b1;
                s_cr    = 32'(int'($urandom_range(0, 32'h4000_0000)) - 32'sh2000_0000);
                s_ci    = 32'(int'($urandom_range(0, 32'h4000_0000)) - 32'sh2000_0000);
                s_tag   = TW'(100 + sent);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = s_valid && s_ready;
            if (acc) sent++;
            step();
            if (acc) s_valid = 1'b0;
        end
        m_ready = 1'b1;
        s_valid = 1'b0;
        checks++; if (res_tag.size() != N) $display("FAIL rand_count: got %0d results expected %0d", res_tag.size(), N); else passes++;
        for (int i = 0; i < res_tag.size(); i++) begin
            checks++;
            if (!exp_iter.exists(res_tag[i]))
                $display("FAIL rand_tag: got unexpected or duplicate tag %0d expected an outstanding tag", res_tag[i]);
            else if (res_iter[i] != exp_iter[res_tag[i]]) begin
                $display("FAIL rand_iter: tag %0d got %0d expected %0d", res_tag[i], res_iter[i], exp_iter[res_tag[i]]);
                exp_iter.delete(res_tag[i]);
            end else begin
                passes++;
                exp_iter.delete(res_tag[i]);
            end
        end
        checks++; if (exp_iter.size() != 0) $display("FAIL rand_outstanding: got %0d unretired pixels expected 0", exp_iter.size()); else passes++;
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_cr    = '0;
        s_ci    = '0;
        s_tag   = '0;
        m_ready = 1'b1;
        test_reset();
        test_escape_pass2();
        test_max_iter();
        test_fill_out_of_order();
        test_output_stall();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fractal_scheduler.md
# fractal_scheduler

Issue and recirculation controller wrapped around `fractal_kernel`. It accepts pixel coordinates (c) on a valid/ready stream and injects each one into a free kernel slot with z = 0. It recirculates unfinished slots back into the kernel and retires finished pixels (iteration count plus tag) onto an output stream. It is the only block that drives the kernel's inputs and the only consumer of its outputs.

## Interface
- `PIPELINE_DEPTH`, 9: kernel latency in cycles; must match the kernel instance.
- `DATA_WIDTH`, 32: width of z/c, signed Q4.28.
- `TAG_WIDTH`, 20: opaque pixel tag carried alongside each slot.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `s_valid` in 1, `s_ready` out 1: new-pixel handshake.
- `s_cr`, `s_ci` in DATA_WIDTH: c for the new pixel.
- `s_tag` in TAG_WIDTH: tag for the new pixel.
- `k_zr`, `k_zi`, `k_cr`, `k_ci` out DATA_WIDTH: kernel data inputs.
- `k_iter` out 8: kernel iteration input.
- `k_finished` out 1: kernel finished input.
- `k_inc_enabled` out 1: kernel iteration-increment enable.
- `k_zr_ret`, `k_zi_ret`, `k_cr_ret`, `k_ci_ret` in DATA_WIDTH: kernel data outputs.
- `k_iter_ret` in 8: kernel iteration output.
- `k_finished_ret` in 1: kernel finished output.
- `m_valid` out 1, `m_ready` in 1: result handshake.
- `m_iter` out 8: final iteration count of the retired pixel.
- `m_tag` out TAG_WIDTH: tag of the retired pixel.

## Operation
- Slot tracking: the kernel carries no valid bit. The block keeps a PIPELINE_DEPTH-entry shift register of {valid, tag}. Entry D-1 (`slot`) describes the data currently on `k_*_ret`.
- `k_*` outputs are combinational from `slot`, `k_*_ret` and `s_*`. The kernel registers them.
- Per-cycle decision on `slot`, in priority order:
  - **Valid, finished, output free** (`!m_valid || m_ready`): load the output register with {`k_iter_ret`, slot tag}; the slot becomes free this cycle.
  - **Valid, finished, output busy:** recirculate all `k_*_ret` values with `k_finished`=1. The iteration count is frozen; z values are don't-care.
  - **Valid, not finished:** recirculate `k_*_ret` values with `k_finished`=0 and `k_inc_enabled`=1.
  - **Slot free** (invalid, or freed by retirement this cycle), `s_valid`=1: inject `k_zr`=`k_zi`=0, `k_cr`/`k_ci`=`s_cr`/`s_ci`, `k_iter`=0, `k_finished`=0, `k_inc_enabled`=1. Push {1, `s_tag`}.
  - **Slot free, no input:** inject a bubble with all data 0, `k_finished`=1, `k_inc_enabled`=0. Push {0, x}.
- `s_ready` = slot free (combinational) and not `reset`.
- Retirement and injection happen in the same cycle when both apply.
- Results may retire out of order; `m_tag` identifies the pixel.
- Termination is decided by the kernel (|z|² > 4 or iter = 255), so an injected pixel always retires within 255 passes plus any output stall.
- Output register: `m_valid`/`m_iter`/`m_tag` are held stable while `m_valid && !m_ready`.

## Timing
- Kernel round trip: inputs driven in cycle t appear on `k_*_ret` in cycle t+PIPELINE_DEPTH.
- A pixel accepted in cycle t that finishes on pass n, with no stall, has `m_valid`=1 in cycle t+n·PIPELINE_DEPTH+1.
- At most PIPELINE_DEPTH pixels are in flight. Sustained acceptance is limited by retirements.
- Reset values: the valid pipe is all 0; `m_valid`=0; `m_iter`=0; `m_tag`=0; `s_ready`=0 while `reset`=1 and 1 in the first cycle after.
- `k_*` drive bubbles while `reset`=1.
- Reset mid-operation discards all in-flight pixels and any pending result. Stale kernel contents are ignored because their valid bits are 0.
- A sustained `m_ready`=0 causes no loss. Finished slots circulate frozen and `s_ready` drops once every slot is occupied.

## Structure
- Shared package `fractal_pkg`:
  - `DATA_WIDTH`, `FRAC_BITS`=28, `PIPELINE_DEPTH`, `MAX_ITER`=255.
  - typedef `slot_meta_t` {valid, tag}.
  - typedef `result_t` {iter, tag}.
- One sub-module, `fractal_slot_pipe`: the PIPELINE_DEPTH-deep resettable delay line of `slot_meta_t`.
- The kernel itself is instantiated by the parent and connected to the `k_*` ports.

## Test plan
- **Escape on pass 2:** single pixel c=(2.5, 0) (0x28000000, 0), tag 5, `m_ready`=1 → `m_iter`=2, `m_tag`=5, `m_valid` in cycle t+2·D+1, exactly one beat.
- **Max-iteration pixel:** c=(0, 0) → `m_iter`=255 at t+255·D+1; no other results.
- **Fill and out-of-order retirement:** 9 back-to-back pixels, tags 0–8, alternating c=0 and c=2.5 → `s_ready` low after 9 accepts; even tags (c=0) retire with `m_iter`=255 and odd tags (c=2.5) retire with `m_iter`=2, out of order, 9 results total, no duplicates.
- **Output stall:** hold `m_ready`=0 for 100 cycles with a finished pixel pending → `m_valid`/`m_iter`/`m_tag` stable; later finished pixels retire with unchanged iteration counts after release.
- **Same-cycle retire and inject:** a finished slot and `s_valid`=1 arrive together with the output free → retire and accept in the same cycle, and the new pixel's result is correct.
- **Reset mid-operation:** assert `reset` with 5 pixels in flight → `m_valid`=0, no stale results ever appear, and `s_ready`=1 in the cycle after reset deasserts.
